// File: rtl/pixel_color_fifo.sv
// Elastic RGB buffer between shader output and HDMI pixel stage.
// Fallback colour on underflow, frame-start flush, saturating debug counters.
module pixel_color_fifo #(
    parameter int          DEPTH        = 16,
    parameter int          ADDR_WIDTH   = 4,
    parameter int          AFULL_LEVEL  = 12,
    parameter logic [23:0] FALLBACK_RGB = 24'h202040
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_valid,
    input  logic [7:0]            wr_red,
    input  logic [7:0]            wr_green,
    input  logic [7:0]            wr_blue,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic [7:0]            rd_red,
    output logic [7:0]            rd_green,
    output logic [7:0]            rd_blue,
    output logic                  rd_underflow,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  full,
    output logic [15:0]           overflow_cnt,
    output logic [15:0]           underflow_cnt
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_L = (ADDR_WIDTH+1)'(AFULL_LEVEL);

    logic [23:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  empty_q, full_q, afull_q;
    logic                  rd_valid_q, rd_uf_q;
    logic [23:0]           rd_rgb_q, rd_rgb_d;
    logic [15:0]           ocnt_q, ocnt_d;
    logic [15:0]           ucnt_q, ucnt_d;
    logic                  wr_ok, rd_ok, ovf, unf;

    // Both sides judged against the pre-edge level; a read frees the full slot.
    always_comb begin
        wr_ok    = 1'b0;
        rd_ok    = 1'b0;
        ovf      = 1'b0;
        unf      = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rd_rgb_d = rd_rgb_q;
        ocnt_d   = ocnt_q;
        ucnt_d   = ucnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            if (rd_en) rd_rgb_d = FALLBACK_RGB;
        end else begin
            rd_ok = rd_en && !empty_q;
            unf   = rd_en && empty_q;
            wr_ok = wr_valid && (!full_q || rd_en);
            ovf   = wr_valid && full_q && !rd_en;
            if (rd_ok) begin
                rd_rgb_d = mem[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (unf) rd_rgb_d = FALLBACK_RGB;
            if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            unique case ({wr_ok, rd_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (ovf && ocnt_q != 16'hFFFF) ocnt_d = ocnt_q + 1'b1;
            if (unf && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_uf_q    <= 1'b0;
            rd_rgb_q   <= FALLBACK_RGB;
            ocnt_q     <= '0;
            ucnt_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= (level_d == '0);
            full_q     <= (level_d == DEPTH_L);
            afull_q    <= (level_d >= AFULL_L);
            rd_valid_q <= rd_en;
            rd_uf_q    <= unf;
            rd_rgb_q   <= rd_rgb_d;
            ocnt_q     <= ocnt_d;
            ucnt_q     <= ucnt_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_ok) begin
            mem[wr_ptr_q] <= {wr_red, wr_green, wr_blue};
        end
    end

    assign rd_valid      = rd_valid_q;
    assign rd_underflow  = rd_uf_q;
    assign rd_red        = rd_rgb_q[23:16];
    assign rd_green      = rd_rgb_q[15:8];
    assign rd_blue       = rd_rgb_q[7:0];
    assign level         = level_q;
    assign almost_full   = afull_q;
    assign empty         = empty_q;
    assign full          = full_q;
    assign overflow_cnt  = ocnt_q;
    assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_pixel_color_fifo.sv
// Randomized scoreboard bench for pixel_color_fifo.
// Queue-based reference model; monitor checks on the falling edge.
module tb_pixel_color_fifo;

    localparam logic [23:0] FB = 24'h202040;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_red = '0, wr_green = '0, wr_blue = '0;
    logic        rd_en = 1'b0;
    logic        rd_valid, rd_underflow, almost_full, empty, full;
    logic [7:0]  rd_red, rd_green, rd_blue;
    logic [4:0]  level;
    logic [15:0] overflow_cnt, underflow_cnt;

    pixel_color_fifo dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_red(wr_red),
        .wr_green(wr_green), .wr_blue(wr_blue),
        .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_red(rd_red), .rd_green(rd_green),
        .rd_blue(rd_blue), .rd_underflow(rd_underflow),
        .level(level), .almost_full(almost_full),
        .empty(empty), .full(full),
        .overflow_cnt(overflow_cnt),
        .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    logic [23:0] mq[$];
    logic [24:0] sbq[$];
    int          ocnt = 0, ucnt = 0;
    logic        exp_valid = 1'b0;
    logic [23:0] exp_rgb = FB;
    logic        started = 1'b0;
    int          tests = 0, fails = 0;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            if (fails < 40)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         name, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic w,
                        input logic [23:0] d, input logic rd);
        int n;
        rst = r; flush = f; wr_valid = w; rd_en = rd;
        {wr_red, wr_green, wr_blue} = d;
        @(posedge clk);
        started = 1'b1;
        if (r) begin
            mq.delete(); sbq.delete();
            ocnt = 0; ucnt = 0;
            exp_valid = 1'b0; exp_rgb = FB;
        end else if (f) begin
            mq.delete();
            exp_valid = rd;
            if (rd) begin
                sbq.push_back({1'b0, FB});
                exp_rgb = FB;
            end
        end else begin
            n = mq.size();
            exp_valid = rd;
            if (rd) begin
                if (n > 0) exp_rgb = mq.pop_front();
                else begin
                    exp_rgb = FB;
                    if (ucnt < 16'hFFFF) ucnt++;
                end
                sbq.push_back({n == 0, exp_rgb});
            end
            if (w) begin
                if (n < 16 || rd) mq.push_back(d);
                else if (ocnt < 16'hFFFF) ocnt++;
            end
        end
        #1;
        rst = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_en = 1'b0;
    endtask

    // Monitor: pops on every presented read, checks status every cycle.
    always @(negedge clk) begin
        logic [24:0] e;
        if (started) begin
            if (rd_valid) begin
                if (sbq.size() == 0) begin
                    chk("sb_spurious", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_data", {rd_red, rd_green, rd_blue}, e[23:0]);
                    chk("sb_underflow", rd_underflow, e[24]);
                end
            end
            chk("rd_valid", rd_valid, exp_valid);
            chk("rd_hold", {rd_red, rd_green, rd_blue}, exp_rgb);
            chk("level", level, mq.size());
            chk("empty", empty, mq.size() == 0);
            chk("full", full, mq.size() == 16);
            chk("almost_full", almost_full, mq.size() >= 12);
            chk("overflow_cnt", overflow_cnt, ocnt);
            chk("underflow_cnt", underflow_cnt, ucnt);
        end
    end

    task automatic rnd_rgb(output logic [23:0] d);
        d = 24'($urandom);
    endtask

    initial begin
        logic [23:0] d;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("reset_rgb", {rd_red, rd_green, rd_blue}, FB);
        // Fill to full plus one dropped write.
        for (int i = 0; i < 17; i++) begin
            d = {8'(i), 8'(i + 1), 8'(i + 2)};
            step(0, 0, 1, d, 0);
        end
        step(0, 0, 0, 0, 0);
        chk("ovf_after_fill", overflow_cnt, 1);
        // Drain plus one underflowing read.
        for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("ufl_after_drain", underflow_cnt, 1);
        // Empty: simultaneous write and read.
        step(0, 0, 1, 24'hAABBCC, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        // Full: simultaneous traffic across pointer wrap.
        for (int i = 0; i < 16; i++) begin
            rnd_rgb(d); step(0, 0, 1, d, 0);
        end
        for (int i = 0; i < 40; i++) begin
            rnd_rgb(d); step(0, 0, 1, d, 1);
        end
        // Level 5 then flush with write and read.
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            rnd_rgb(d); step(0, 0, 1, d, 0);
        end
        step(0, 1, 1, 24'h123456, 1);
        step(0, 0, 0, 0, 0);
        chk("flush_level", level, 0);
        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            rnd_rgb(d);
            step(0, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 99) < 55, d,
                 $urandom_range(0, 99) < 50);
        end
        // Saturate the underflow counter.
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 70000; i++) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("ufl_saturated", underflow_cnt, 16'hFFFF);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        step(1, 0, 1, 24'h777777, 1);
        @(negedge clk);
        chk("rst_valid", rd_valid, 0);
        chk("rst_uf", rd_underflow, 0);
        chk("rst_ucnt", underflow_cnt, 0);
        chk("rst_level", level, 0);
        step(0, 0, 0, 0, 0);
        chk("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
